// File: rtl/siso_pkg.sv
// Shared types for the serial scheduler: FSM state encoding and requester ids.
package siso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/siso_shifter.sv
// Parallel-load, shift-right register; bit 0 is the serial output.
module siso_shifter
  import siso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_so
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_din;
    end else if (i_shift) begin
      r_data <= {1'b0, r_data[WIDTH-1:1]};
    end
  end

  assign o_so = r_data[0];

endmodule

// File: rtl/siso_sched.sv
// Two-requester round-robin scheduler feeding one LSB-first serial line.
// Optional trailing even-parity bit: define SISO_SCHED_PARITY_EN.
module siso_sched
  import siso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             so,
  output logic             busy,
  output logic             owner,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ptr;
  logic            r_owner;
  logic            r_gnt0;
  logic            r_gnt1;
  logic            w_any;
  logic            w_win;
  logic            w_load;
  logic            w_shift;
  logic            w_sh_so;
  logic [WIDTH-1:0] w_din;
`ifdef SISO_SCHED_PARITY_EN
  logic            r_par;
`endif

  assign w_any   = req0 | req1;
  // Pointer only breaks ties; a lone requester always wins.
  assign w_win   = (req0 & req1) ? r_ptr : req1;
  assign w_din   = (w_win == REQ1) ? din1 : din0;
  assign w_load  = (r_state == IDLE) & w_any;
  assign w_shift = (r_state == SHIFT);

  siso_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_din   (w_din),
    .o_so    (w_sh_so)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= REQ0;
      r_owner <= REQ0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
`ifdef SISO_SCHED_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_ptr   <= ~w_win;
            r_gnt0  <= (w_win == REQ0);
            r_gnt1  <= (w_win == REQ1);
`ifdef SISO_SCHED_PARITY_EN
            r_par   <= ^w_din;
`endif
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
`ifdef SISO_SCHED_PARITY_EN
            r_state <= PAR;
`else
            r_state <= DONE;
`endif
          end
        end
`ifdef SISO_SCHED_PARITY_EN
        PAR:  r_state <= DONE;
`endif
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    so = 1'b0;
    if (r_state == SHIFT) so = w_sh_so;
`ifdef SISO_SCHED_PARITY_EN
    if (r_state == PAR) so = r_par;
`endif
  end

  assign busy  = (r_state == SHIFT) | (r_state == PAR);
  assign done  = (r_state == DONE);
  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign owner = r_owner;

endmodule

// File: tb/tb_siso_sched.sv
// Scoreboard bench for siso_sched: expected serial bits queued at request time.
module tb_siso_sched;

  localparam int W = 4;
`ifdef SISO_SCHED_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct packed {
    logic b;
    logic own;
  } exp_t;

  logic clk = 1'b0;
  logic rst, req0, req1;
  logic [W-1:0] din0, din1;
  logic gnt0, gnt1, so, busy, owner, done;

  exp_t sb[$];
  logic gq[$];
  int   gc[$];
  int   dc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_n, done_n, n0, n1;

  always #5 clk = ~clk;

  siso_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .din0  (din0),
    .req1  (req1),
    .din1  (din1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .so    (so),
    .busy  (busy),
    .owner (owner),
    .done  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    gq.delete();
    gc.delete();
    dc.delete();
    busy_n = 0;
    done_n = 0;
  endtask

  task automatic push_frame(input logic who, input logic [W-1:0] d);
    for (int i = 0; i < W; i++) sb.push_back('{b: d[i], own: who});
`ifdef SISO_SCHED_PARITY_EN
    sb.push_back('{b: ^d, own: who});
`endif
  endtask

  task automatic watch(input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      tick();
      total++;
      if (gnt0 & gnt1) begin
        bad++;
        $display("FAIL gnt_excl: gnt0=%b gnt1=%b want not both", gnt0, gnt1);
      end
      if (gnt0) begin
        gq.push_back(1'b0);
        gc.push_back(cyc);
        n0--;
        if (n0 <= 0) req0 = 1'b0;
      end
      if (gnt1) begin
        gq.push_back(1'b1);
        gc.push_back(cyc);
        n1--;
        if (n1 <= 0) req1 = 1'b0;
      end
      total++;
      if (busy) begin
        busy_n++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_empty: busy=1 with no expected bit, so=%b", so);
        end else begin
          e = sb.pop_front();
          if ({so, owner} !== {e.b, e.own}) begin
            bad++;
            $display("FAIL serial: so/owner=%b%b want %b%b cyc=%0d",
                     so, owner, e.b, e.own, cyc);
          end
        end
      end else if (so !== 1'b0) begin
        bad++;
        $display("FAIL so_idle: so=%b want 0 cyc=%0d", so, cyc);
      end
      if (done) begin
        done_n++;
        dc.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; din0 = '0; din1 = '0;
    rst = 1'b1;
    #3;
    total++;
    if ({gnt0, gnt1, so, busy, done, owner} !== 6'b0) begin
      bad++;
      $display("FAIL reset_out: got %b want 000000",
               {gnt0, gnt1, so, busy, done, owner});
    end
    tick();
    rst = 1'b0;
    clear_log();
    watch(2);
    total++;
    if (gq.size() != 0 || busy_n != 0) begin
      bad++;
      $display("FAIL reset_idle: grants=%0d busy=%0d want 0 0", gq.size(), busy_n);
    end
  endtask

  task automatic test_single();
    clear_log();
    push_frame(1'b0, 4'b1011);
    din0 = 4'b1011; req0 = 1; n0 = 1;
    watch(FL + 4);
    total++;
    if (gq.size() != 1 || gq[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_gnt: grants=%0d want one gnt0", gq.size());
    end
    total++;
    if (busy_n != FL) begin
      bad++;
      $display("FAIL single_busy: busy=%0d want %0d", busy_n, FL);
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL single_done: done=%0d want 1", done_n);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL single_left: left=%0d want 0", sb.size());
    end
  endtask

  task automatic test_contention();
    do_reset();
    clear_log();
    push_frame(1'b0, 4'hA);
    push_frame(1'b1, 4'h5);
    din0 = 4'hA; din1 = 4'h5;
    req0 = 1; req1 = 1; n0 = 1; n1 = 1;
    watch(2 * (FL + 2) + 4);
    total++;
    if (gq.size() != 2 || gq[0] !== 1'b0 || gq[1] !== 1'b1) begin
      bad++;
      $display("FAIL cont_order: grants=%0d want 0 then 1", gq.size());
    end else begin
      total++;
      if (gc[1] - dc[0] != 2) begin
        bad++;
        $display("FAIL cont_gap: gap=%0d want 2", gc[1] - dc[0]);
      end
    end
    total++;
    if (sb.size() != 0 || done_n != 2) begin
      bad++;
      $display("FAIL cont_done: left=%0d done=%0d want 0 2", sb.size(), done_n);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] got;
    clear_log();
    din0 = 4'h3; din1 = 4'hC;
    push_frame(1'b0, 4'h3);
    push_frame(1'b1, 4'hC);
    push_frame(1'b0, 4'h3);
    push_frame(1'b1, 4'hC);
    req0 = 1; req1 = 1; n0 = 2; n1 = 2;
    watch(4 * (FL + 2) + 4);
    got = '0;
    foreach (gq[i]) got = {got[6:0], gq[i]};
    total++;
    if (gq.size() != 4 || got[3:0] !== 4'b0101) begin
      bad++;
      $display("FAIL fair_order: n=%0d order=%b want 4 0101", gq.size(), got[3:0]);
    end
    total++;
    if (done_n != 4 || sb.size() != 0) begin
      bad++;
      $display("FAIL fair_done: done=%0d left=%0d want 4 0", done_n, sb.size());
    end
  endtask

  task automatic test_withdrawn();
    clear_log();
    push_frame(1'b0, 4'h6);
    din0 = 4'h6; din1 = 4'h9;
    req0 = 1; n0 = 1; n1 = 1;
    watch(2);
    req1 = 1;
    watch(1);
    req1 = 0;
    watch(FL + 4);
    total++;
    if (gq.size() != 1 || gq[0] !== 1'b0) begin
      bad++;
      $display("FAIL wd_gnt: grants=%0d want only gnt0", gq.size());
    end
    total++;
    if (done_n != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL wd_done: done=%0d left=%0d want 1 0", done_n, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    push_frame(1'b0, 4'hF);
    din0 = 4'hF; req0 = 1; n0 = 1;
    watch(2);
    rst = 1'b1;
    #1;
    total++;
    if ({so, busy, gnt0, gnt1, done, owner} !== 6'b0) begin
      bad++;
      $display("FAIL mid_rst: so/busy/g0/g1/done/own=%b want 000000",
               {so, busy, gnt0, gnt1, done, owner});
    end
    sb.delete();
    tick();
    rst = 1'b0;
    clear_log();
    watch(3);
    total++;
    if (done_n != 0 || busy_n != 0) begin
      bad++;
      $display("FAIL mid_nodone: done=%0d busy=%0d want 0 0", done_n, busy_n);
    end
    clear_log();
    push_frame(1'b0, 4'h9);
    push_frame(1'b1, 4'h6);
    din0 = 4'h9; din1 = 4'h6;
    req0 = 1; req1 = 1; n0 = 1; n1 = 1;
    watch(2 * (FL + 2) + 4);
    total++;
    if (gq.size() != 2 || gq[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_ptr: grants=%0d first=%b want 2 0", gq.size(), gq[0]);
    end
    clear_log();
    push_frame(1'b1, 4'h3);
    din1 = 4'h3; req1 = 1; n1 = 1;
    watch(FL + 4);
    total++;
    if (gq.size() != 1 || gq[0] !== 1'b1 || done_n != 1) begin
      bad++;
      $display("FAIL mid_req1: grants=%0d done=%0d want 1 gnt1 1 done",
               gq.size(), done_n);
    end
  endtask

`ifdef SISO_SCHED_PARITY_EN
  task automatic test_parity();
    clear_log();
    push_frame(1'b0, 4'b0111);
    din0 = 4'b0111; req0 = 1; n0 = 1;
    watch(W + 5);
    total++;
    if (busy_n != 5 || sb.size() != 0) begin
      bad++;
      $display("FAIL parity: busy=%0d left=%0d want 5 0", busy_n, sb.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_withdrawn();
    test_reset_mid();
`ifdef SISO_SCHED_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
